// File: rtl/sseg_scan_capture_pkg.sv
// Shared definitions for the seven-segment scan capture monitor:
// FSM state encoding, idle bus constants and the anode select decoder.
package sseg_scan_capture_pkg;

    typedef enum logic {
        SETTLING = 1'b0,
        HOLD     = 1'b1
    } cap_state_t;

    localparam logic [7:0] SEG_BLANK  = 8'hFF;
    localparam logic [3:0] ANODE_NONE = 4'hF;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } anode_dec_t;

    // Slot index and one-hot-valid flag for an active-low anode select.
    function automatic anode_dec_t anode_decode(input logic [3:0] an);
        anode_dec_t r;
        r.valid = 1'b1;
        r.idx   = 2'd0;
        case (an)
            4'b1110: r.idx = 2'd0;
            4'b1101: r.idx = 2'd1;
            4'b1011: r.idx = 2'd2;
            4'b0111: r.idx = 2'd3;
            default: r.valid = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sseg_scan_capture_input_sync.sv
// Parameterised 2-flop synchronizer for the snooped anode/segment bus.
// Both stages reset to RST_VAL so the bus reads as idle out of reset.
// Only instantiated when SSEG_CAPTURE_SYNC_EN is defined.
module sseg_input_sync #(
    parameter int             W       = 12,
    parameter logic [W-1:0]   RST_VAL = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    // Two back-to-back flops resolve metastability on the asynchronous bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/sseg_scan_capture.sv
// Seven-segment scan bus monitor: de-glitches the multiplexed anode/segment
// bus and rebuilds the four digit patterns into a parallel frame.
// Optional macro SSEG_CAPTURE_SYNC_EN inserts a 2-flop synchronizer on the
// inputs (adds two cycles to every latency) for an asynchronous bus.
module sseg_scan_capture
    import sseg_scan_capture_pkg::*;
#(
    parameter int SETTLE    = 4,
    parameter int TIMEOUT_W = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  anode,
    input  logic [7:0]  sseg_in,
    output logic [31:0] digits,
    output logic        frame_valid,
    output logic        frame_err,
    output logic        stale
);

    localparam int                CNT_W   = $clog2(SETTLE) + 1;
    // Accept fires on the cycle whose increment brings the count to SETTLE-1.
    localparam logic [CNT_W-1:0]  CNT_ACC = CNT_W'(SETTLE - 2);

    logic [3:0]            w_anode;
    logic [7:0]            w_seg;
    logic [11:0]           w_sample;
    logic                  w_same;

    cap_state_t            r_state;
    cap_state_t            w_state_next;
    logic [CNT_W-1:0]      r_stab_cnt;
    logic [CNT_W-1:0]      w_cnt_next;
    logic                  w_accept;
    logic [11:0]           r_prev;

    anode_dec_t            w_dec;
    logic                  w_blank;
    logic                  w_multi;
    logic [3:0]            w_slot_oh;
    logic [3:0]            w_seen_set;
    logic [31:0]           w_shadow_wr;

    logic [31:0]           r_shadow;
    logic [3:0]            r_seen;
    logic [31:0]           r_digits;
    logic                  r_frame_valid;
    logic                  r_frame_err;
    logic [TIMEOUT_W-1:0]  r_idle;

`ifdef SSEG_CAPTURE_SYNC_EN
    sseg_input_sync #(
        .W       (12),
        .RST_VAL ({ANODE_NONE, SEG_BLANK})
    ) u_input_sync (
        .clk (clk),
        .rst (rst),
        .i_d ({anode, sseg_in}),
        .o_q ({w_anode, w_seg})
    );
`else
    assign w_anode = anode;
    assign w_seg   = sseg_in;
`endif

    assign w_sample = {w_anode, w_seg};
    assign w_same   = (w_sample == r_prev);

    // Stability FSM state, dwell counter and previous-sample register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= SETTLING;
            r_stab_cnt <= '0;
            r_prev     <= {ANODE_NONE, SEG_BLANK};
        end else begin
            r_state    <= w_state_next;
            r_stab_cnt <= w_cnt_next;
            r_prev     <= w_sample;
        end
    end

    // Next state: any change restarts settling; one accept per stable dwell.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_stab_cnt;
        w_accept     = 1'b0;
        if (!w_same) begin
            w_state_next = SETTLING;
            w_cnt_next   = '0;
        end else if (r_state == SETTLING) begin
            w_cnt_next = r_stab_cnt + CNT_W'(1);
            if (r_stab_cnt == CNT_ACC) begin
                w_accept     = 1'b1;
                w_state_next = HOLD;
            end
        end
    end

    assign w_dec      = anode_decode(w_anode);
    assign w_blank    = (w_anode == ANODE_NONE);
    assign w_multi    = !w_dec.valid && !w_blank;
    assign w_slot_oh  = 4'b0001 << w_dec.idx;
    assign w_seen_set = r_seen | w_slot_oh;

    // Shadow with the accepted pattern merged into its slot, so a frame
    // completed on this edge includes the final digit.
    always_comb begin
        w_shadow_wr = r_shadow;
        case (w_dec.idx)
            2'd0:    w_shadow_wr[7:0]   = w_seg;
            2'd1:    w_shadow_wr[15:8]  = w_seg;
            2'd2:    w_shadow_wr[23:16] = w_seg;
            default: w_shadow_wr[31:24] = w_seg;
        endcase
    end

    // Accept classification: slot write / frame completion / select error.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow      <= '1;
            r_seen        <= '0;
            r_digits      <= '1;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
            if (w_accept && w_dec.valid) begin
                r_shadow <= w_shadow_wr;
                if (w_seen_set == 4'hF) begin
                    r_digits      <= w_shadow_wr;
                    r_frame_valid <= 1'b1;
                    r_seen        <= '0;
                end else begin
                    r_seen <= w_seen_set;
                end
            end else if (w_accept && w_multi) begin
                r_frame_err <= 1'b1;
                r_seen      <= '0;
            end
        end
    end

    // Idle counter: cleared by any non-blank accept, otherwise saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idle <= '0;
        end else if (w_accept && !w_blank) begin
            r_idle <= '0;
        end else if (r_idle != '1) begin
            r_idle <= r_idle + TIMEOUT_W'(1);
        end
    end

    assign digits      = r_digits;
    assign frame_valid = r_frame_valid;
    assign frame_err   = r_frame_err;
    assign stale       = (r_idle == '1);

endmodule

// File: tb/tb_sseg_scan_capture.sv
// Directed bench for sseg_scan_capture (SETTLE=4, TIMEOUT_W=4).
// Build with SSEG_CAPTURE_SYNC_EN to exercise the synchronized input path.
module tb_sseg_scan_capture;

    localparam int SETTLE    = 4;
    localparam int TIMEOUT_W = 4;
`ifdef SSEG_CAPTURE_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    // Active-low {dp,g,f,e,d,c,b,a} patterns.
    localparam logic [7:0]  SEG_7 = 8'hF8;
    localparam logic [7:0]  SEG_3 = 8'hB0;
    localparam logic [7:0]  SEG_1 = 8'hF9;
    localparam logic [7:0]  SEG_8 = 8'h80;
    localparam logic [31:0] FRAME_7318 = 32'hF8B0_F980;
    localparam logic [31:0] ALL_ONES   = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  anode = 4'hF;
    logic [7:0]  sseg_in = 8'hFF;
    logic [31:0] digits;
    logic        frame_valid;
    logic        frame_err;
    logic        stale;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fv_cnt = 0;
    int fe_cnt = 0;
    int both_cnt = 0;
    int fv_cyc = -1;
    int fv_base;
    int fe_base;
    int start;

    sseg_scan_capture #(
        .SETTLE    (SETTLE),
        .TIMEOUT_W (TIMEOUT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .anode       (anode),
        .sseg_in     (sseg_in),
        .digits      (digits),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .stale       (stale)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (frame_valid) begin
            fv_cnt <= fv_cnt + 1;
            fv_cyc <= cyc;
        end
        if (frame_err) fe_cnt <= fe_cnt + 1;
        if (frame_valid && frame_err) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic scan(input logic [3:0] an, input logic [7:0] seg, input int n);
        anode   = an;
        sseg_in = seg;
        step(n);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        anode   = 4'hF;
        sseg_in = 8'hFF;
        step(3);
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_digits", digits, ALL_ONES);
        check("rst_fv", 32'(frame_valid), 32'd0);
        check("rst_fe", 32'(frame_err), 32'd0);
        check("rst_stale", 32'(stale), 32'd0);

        // Scenario 1: scan 7,3,1,8 each for 8 cycles
        fv_base = fv_cnt;
        fe_base = fe_cnt;
        scan(4'b0111, SEG_7, 8);
        scan(4'b1011, SEG_3, 8);
        scan(4'b1101, SEG_1, 8);
        check("s1_partial_fv", 32'(fv_cnt - fv_base), 32'd0);
        check("s1_partial_digits", digits, ALL_ONES);
        anode   = 4'b1110;
        sseg_in = SEG_8;
        start   = cyc;
        step(8);
        check("s1_fv_count", 32'(fv_cnt - fv_base), 32'd1);
        check("s1_fv_cycle", 32'(fv_cyc), 32'(start + SETTLE + LAT));
        check("s1_digits", digits, FRAME_7318);
        check("s1_no_err", 32'(fe_cnt - fe_base), 32'd0);

        // Scenario 2: 3-cycle glitch on slot 2 is rejected
        do_reset();
        fv_base = fv_cnt;
        scan(4'b1011, 8'h00, SETTLE - 1);
        scan(4'b0111, SEG_7, 8);
        scan(4'b1101, SEG_1, 8);
        scan(4'b1110, SEG_8, 8);
        check("s2_glitch_no_fv", 32'(fv_cnt - fv_base), 32'd0);
        check("s2_glitch_digits", digits, ALL_ONES);
        scan(4'b1011, SEG_3, 8);
        check("s2_fv_count", 32'(fv_cnt - fv_base), 32'd1);
        check("s2_digits", digits, FRAME_7318);

        // Scenario 3: two anodes low mid-frame
        do_reset();
        fv_base = fv_cnt;
        fe_base = fe_cnt;
        scan(4'b0111, SEG_7, 8);
        scan(4'b1011, SEG_3, 8);
        scan(4'b0011, 8'h00, 6);
        scan(4'b1101, SEG_1, 8);
        check("s3_err_count", 32'(fe_cnt - fe_base), 32'd1);
        scan(4'b1110, SEG_8, 8);
        check("s3_seen_cleared", 32'(fv_cnt - fv_base), 32'd0);
        scan(4'b0111, SEG_7, 8);
        scan(4'b1011, SEG_3, 8);
        check("s3_fv_count", 32'(fv_cnt - fv_base), 32'd1);
        check("s3_digits", digits, FRAME_7318);
        check("s3_err_total", 32'(fe_cnt - fe_base), 32'd1);

        // Scenario 4: blank-only bus goes stale after 15 cycles
        do_reset();
        step(14);
        check("s4_stale_before", 32'(stale), 32'd0);
        step(1);
        check("s4_stale_rise", 32'(stale), 32'd1);
        step(5);
        check("s4_stale_saturate", 32'(stale), 32'd1);
        scan(4'b1110, SEG_8, SETTLE - 1 + LAT);
        check("s4_stale_until_accept", 32'(stale), 32'd1);
        step(1);
        check("s4_stale_clear", 32'(stale), 32'd0);

        // Scenario 5: reset discards a partial frame
        do_reset();
        fv_base = fv_cnt;
        scan(4'b0111, SEG_7, 8);
        scan(4'b1011, SEG_3, 8);
        scan(4'b1101, SEG_1, 8);
        do_reset();
        check("s5_rst_digits", digits, ALL_ONES);
        scan(4'b1110, SEG_8, 8);
        step(2);
        check("s5_no_fv", 32'(fv_cnt - fv_base), 32'd0);
        check("s5_digits", digits, ALL_ONES);

        check("never_both", 32'(both_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
